// File: rtl/snake_dir_scheduler.sv
// rtl/snake_dir_scheduler.sv - IR turn filter, holdoff rate limiter and per-tick turn queue for the snake engine
module snake_dir_scheduler #(
   parameter int         DEPTH          = 4,
   parameter int         HOLDOFF_CYCLES = 50000,
   parameter logic [1:0] INIT_DIR       = 2'd3
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic                   game_over,
   input  logic                   cmd_valid,
   input  logic [1:0]             cmd_dir,
   input  logic                   tick,
   output logic [1:0]             cur_dir,
   output logic                   dir_update,
   output logic                   running,
   output logic [$clog2(DEPTH):0] queue_count,
   output logic [7:0]             drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

   localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLDOFF_CYCLES);
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   logic [0:0]    state;
   logic [1:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] tail_idx;
   logic [HW-1:0] holdoff;

   logic       in_run;
   logic       flush;
   logic       fifo_empty;
   logic       fifo_full;
   logic [1:0] ref_dir;
   logic [1:0] opp_dir;
   logic       legal;
   logic       do_pop;
   logic       do_push;
   logic       do_drop;

   assign running = (state == ST_RUN);

   assign in_run     = (state == ST_RUN);
   assign flush      = start | game_over;
   assign fifo_empty = (queue_count == '0);
   assign fifo_full  = (queue_count == FULL_COUNT);
   assign tail_idx   = wr_ptr - AW'(1);

   // Turns are judged against the last queued turn, not the one currently applied.
   assign ref_dir = fifo_empty ? cur_dir : mem[tail_idx];
   assign opp_dir = {ref_dir[1], ~ref_dir[0]};

   assign do_pop = in_run && !flush && tick && !fifo_empty;

   always_comb begin
      legal = 1'b1;
      if (holdoff != '0) begin
         legal = 1'b0;
      end
      if (cmd_dir == ref_dir || cmd_dir == opp_dir) begin
         legal = 1'b0;
      end
      // A same-edge pop frees the slot this push needs.
      if (fifo_full && !do_pop) begin
         legal = 1'b0;
      end
   end

   assign do_push = in_run && !flush && cmd_valid && legal;
   assign do_drop = in_run && !flush && cmd_valid && !legal;

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= cmd_dir;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         cur_dir     <= INIT_DIR;
         dir_update  <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_count <= '0;
         drop_count  <= '0;
         holdoff     <= '0;
      end else begin
         dir_update <= 1'b0;
         if (holdoff != '0) begin
            holdoff <= holdoff - HW'(1);
         end

         if (game_over) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
         end else if (start) begin
            state       <= ST_RUN;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_count <= '0;
            cur_dir     <= INIT_DIR;
            holdoff     <= '0;
            drop_count  <= '0;
         end else begin
            if (do_pop) begin
               cur_dir    <= mem[rd_ptr];
               rd_ptr     <= rd_ptr + AW'(1);
               dir_update <= 1'b1;
            end
            if (do_push) begin
               wr_ptr  <= wr_ptr + AW'(1);
               holdoff <= HOLD_LOAD;
            end
            if (do_drop && drop_count != 8'hFF) begin
               drop_count <= drop_count + 8'd1;
            end
            case ({do_push, do_pop})
               2'b10:   queue_count <= queue_count + CW'(1);
               2'b01:   queue_count <= queue_count - CW'(1);
               default: queue_count <= queue_count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_snake_dir_scheduler.sv
// tb/tb_snake_dir_scheduler.sv - randomized bench for snake_dir_scheduler with holdoff=4 and holdoff=0 instances
module tb_snake_dir_scheduler;

   localparam int         DEPTH    = 4;
   localparam logic [1:0] INIT_DIR = 2'd3;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic       game_over;
   logic       cmd_valid;
   logic [1:0] cmd_dir;
   logic       tick;

   logic [1:0] h4_cur_dir, h0_cur_dir;
   logic       h4_dir_update, h0_dir_update;
   logic       h4_running, h0_running;
   logic [2:0] h4_queue_count, h0_queue_count;
   logic [7:0] h4_drop_count, h0_drop_count;

   always #5 clk = ~clk;

   snake_dir_scheduler #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(4), .INIT_DIR(INIT_DIR)) u_dut_h4 (
      .clk(clk), .reset_n(reset_n), .start(start), .game_over(game_over),
      .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .tick(tick),
      .cur_dir(h4_cur_dir), .dir_update(h4_dir_update), .running(h4_running),
      .queue_count(h4_queue_count), .drop_count(h4_drop_count)
   );

   snake_dir_scheduler #(.DEPTH(DEPTH), .HOLDOFF_CYCLES(0), .INIT_DIR(INIT_DIR)) u_dut_h0 (
      .clk(clk), .reset_n(reset_n), .start(start), .game_over(game_over),
      .cmd_valid(cmd_valid), .cmd_dir(cmd_dir), .tick(tick),
      .cur_dir(h0_cur_dir), .dir_update(h0_dir_update), .running(h0_running),
      .queue_count(h0_queue_count), .drop_count(h0_drop_count)
   );

   int checks = 0;
   int passes = 0;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got == exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: index 0 = holdoff 4 instance, index 1 = holdoff 0 instance.
   typedef logic [1:0] dq_t[$];
   dq_t mq [2];
   int  hold_cfg [2] = '{4, 0};
   int  m_cur [2];
   int  m_run [2];
   int  m_hold [2];
   int  m_drop [2];
   int  m_upd [2];

   function automatic int opposite(input int d);
      case (d)
         0:       return 1;
         1:       return 0;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         mq[i].delete();
         m_cur[i]  = INIT_DIR;
         m_run[i]  = 0;
         m_hold[i] = 0;
         m_drop[i] = 0;
         m_upd[i]  = 0;
      end
   endtask

   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int next_hold;
         int ref_d;
         bit pop;
         bit ok;
         m_upd[i]  = 0;
         next_hold = (m_hold[i] > 0) ? m_hold[i] - 1 : 0;
         if (game_over) begin
            m_run[i] = 0;
            mq[i].delete();
         end else if (start) begin
            m_run[i] = 1;
            mq[i].delete();
            m_cur[i]  = INIT_DIR;
            next_hold = 0;
            m_drop[i] = 0;
         end else if (m_run[i] != 0) begin
            pop   = tick && (mq[i].size() > 0);
            ref_d = (mq[i].size() > 0) ? int'(mq[i][$]) : m_cur[i];
            ok    = cmd_valid && (m_hold[i] == 0) && (int'(cmd_dir) != ref_d) &&
                    (int'(cmd_dir) != opposite(ref_d)) && ((mq[i].size() < DEPTH) || pop);
            if (pop) begin
               m_cur[i] = int'(mq[i].pop_front());
               m_upd[i] = 1;
            end
            if (ok) begin
               mq[i].push_back(cmd_dir);
               next_hold = hold_cfg[i];
            end else if (cmd_valid && m_drop[i] < 255) begin
               m_drop[i]++;
            end
         end
         m_hold[i] = next_hold;
      end
   endtask

   task automatic compare_all();
      check("h4_cur_dir", h4_cur_dir, m_cur[0]);
      check("h4_dir_update", h4_dir_update, m_upd[0]);
      check("h4_running", h4_running, m_run[0]);
      check("h4_queue_count", h4_queue_count, mq[0].size());
      check("h4_drop_count", h4_drop_count, m_drop[0]);
      check("h0_cur_dir", h0_cur_dir, m_cur[1]);
      check("h0_dir_update", h0_dir_update, m_upd[1]);
      check("h0_running", h0_running, m_run[1]);
      check("h0_queue_count", h0_queue_count, mq[1].size());
      check("h0_drop_count", h0_drop_count, m_drop[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      start     = 1'b0;
      game_over = 1'b0;
      cmd_valid = 1'b0;
      tick      = 1'b0;
   endtask

   task automatic drive(input bit cv, input int cd, input bit tk, input bit st, input bit go);
      cmd_valid = cv;
      cmd_dir   = 2'(cd);
      tick      = tk;
      start     = st;
      game_over = go;
      cycle();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_h4_cur"}, h4_cur_dir, INIT_DIR);
      check({pfx, "_h4_run"}, h4_running, 0);
      check({pfx, "_h4_qc"}, h4_queue_count, 0);
      check({pfx, "_h4_drop"}, h4_drop_count, 0);
      check({pfx, "_h4_upd"}, h4_dir_update, 0);
      check({pfx, "_h0_cur"}, h0_cur_dir, INIT_DIR);
      check({pfx, "_h0_run"}, h0_running, 0);
      check({pfx, "_h0_qc"}, h0_queue_count, 0);
      check({pfx, "_h0_drop"}, h0_drop_count, 0);
      check({pfx, "_h0_upd"}, h0_dir_update, 0);
   endtask

   // Called just after a posedge: reset drops mid-cycle and releases before the next edge.
   task automatic async_reset_pulse(input string pfx);
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_values(pfx);
      model_reset();
      #1;
      reset_n   = 1'b1;
      start     = 1'b0;
      game_over = 1'b0;
      cmd_valid = 1'b0;
      tick      = 1'b0;
   endtask

   initial begin
      reset_n   = 1'b0;
      start     = 1'b0;
      game_over = 1'b0;
      cmd_valid = 1'b0;
      cmd_dir   = 2'd0;
      tick      = 1'b0;
      model_reset();
      #12;
      check_reset_values("por");
      reset_n = 1'b1;

      // Accept one turn, apply it on the next tick.
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      check("t1_qc", h4_queue_count, 1);
      drive(0, 0, 1, 0, 0);
      check("t1_cur", h4_cur_dir, 0);
      check("t1_upd", h4_dir_update, 1);
      check("t1_qc_after", h4_queue_count, 0);
      idle(1);
      check("t1_upd_pulse", h4_dir_update, 0);

      // Reversal and no-op rejected.
      drive(0, 0, 0, 1, 0);
      drive(1, 2, 0, 0, 0);
      idle(6);
      drive(1, 3, 0, 0, 0);
      check("t2_drop", h4_drop_count, 2);
      check("t2_qc", h4_queue_count, 0);

      // Holdoff window, then FIFO order.
      drive(1, 0, 0, 0, 0);
      idle(1);
      drive(1, 2, 0, 0, 0);
      check("t3_drop_holdoff", h4_drop_count, 3);
      idle(2);
      drive(1, 2, 0, 0, 0);
      check("t3_qc", h4_queue_count, 2);
      drive(0, 0, 1, 0, 0);
      check("t3_first", h4_cur_dir, 0);
      drive(0, 0, 1, 0, 0);
      check("t3_second", h4_cur_dir, 2);

      // Fill to DEPTH with no holdoff, overflow, then push-with-pop at full.
      drive(0, 0, 0, 1, 0);
      drive(1, 0, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      drive(1, 3, 0, 0, 0);
      check("t4_full", h0_queue_count, 4);
      drive(1, 0, 0, 0, 0);
      check("t4_overflow_drop", h0_drop_count, 1);
      check("t4_overflow_qc", h0_queue_count, 4);
      drive(1, 0, 1, 0, 0);
      check("t4_pushpop_qc", h0_queue_count, 4);
      check("t4_pushpop_cur", h0_cur_dir, 0);
      check("t4_pushpop_drop", h0_drop_count, 1);

      // game_over flushes; IDLE ignores commands; start reloads.
      drive(0, 0, 1, 0, 0);
      drive(0, 0, 1, 0, 0);
      check("t5_qc2", h0_queue_count, 2);
      check("t5_cur", h0_cur_dir, 1);
      drive(0, 0, 0, 0, 1);
      check("t5_run", h0_running, 0);
      check("t5_qc", h0_queue_count, 0);
      drive(1, 0, 1, 0, 0);
      check("t5_idle_cur", h0_cur_dir, 1);
      check("t5_idle_drop", h0_drop_count, 1);
      drive(0, 0, 0, 1, 1);
      check("t5_go_wins", h0_running, 0);
      drive(0, 0, 0, 1, 0);
      check("t5_start_cur", h0_cur_dir, 3);
      check("t5_start_drop", h0_drop_count, 0);
      check("t5_start_run", h0_running, 1);

      // Async reset with pending turns.
      drive(1, 0, 0, 0, 0);
      drive(1, 2, 0, 0, 0);
      drive(1, 1, 0, 0, 0);
      check("t6_qc3", h0_queue_count, 3);
      tick = 1'b1;
      async_reset_pulse("t6_async");

      // Drop counter saturation.
      drive(0, 0, 0, 1, 0);
      for (int k = 0; k < 300; k++) drive(1, 3, 0, 0, 0);
      check("t6_sat_h0", h0_drop_count, 255);
      check("t6_sat_h4", h4_drop_count, 255);

      // Randomized traffic.
      drive(0, 0, 0, 1, 0);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 799) == 0) begin
            async_reset_pulse("rnd_async");
         end else begin
            drive($urandom_range(0, 9) < 5, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
                  $urandom_range(0, 119) == 0, $urandom_range(0, 179) == 0);
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/snake_dir_scheduler.md
Name: snake_dir_scheduler

Overview:
- Sits between the IR receiver/decoder and the snake game engine.
- Accepts decoded direction commands (strobe + 2-bit code) and filters illegal turns: no-ops and 180° reversals.
- Rate-limits IR repeats with a holdoff counter.
- Buffers accepted turns in a small FIFO and releases exactly one turn per game tick, so fast button presses are neither lost nor applied mid-step.
- Includes a run/idle state machine that flushes state at game start and game over.

Parameters:
DEPTH, 4, turn FIFO depth; power of two, at least 2
HOLDOFF_CYCLES, 50000, minimum clk cycles between accepted commands; 0 disables holdoff
INIT_DIR, 2'd3, direction loaded at game start (0=up, 1=down, 2=left, 3=right)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse: begin game
game_over  in  1  one-cycle pulse: end game
cmd_valid  in  1  one-cycle strobe: new decoded IR command
cmd_dir  in  2  command direction (0=up, 1=down, 2=left, 3=right); valid with cmd_valid
tick  in  1  one-cycle pulse: game step boundary
cur_dir  out  2  direction currently applied by the game engine
dir_update  out  1  one-cycle pulse: cur_dir changed this step
running  out  1  high in RUN state
queue_count  out  $clog2(DEPTH)+1  number of pending turns
drop_count  out  8  count of rejected commands; saturates at 255

Behaviour:
- Reset (async, reset_n low):
  - state=IDLE, cur_dir=INIT_DIR, dir_update=0, running=0.
  - FIFO empty, queue_count=0, drop_count=0, holdoff counter=0.
  - Reset mid-operation discards all pending turns immediately.
- States:
  - IDLE: cmd_valid and tick are ignored; commands in IDLE do not count as drops.
  - IDLE -> RUN on start: same edge flushes FIFO, loads cur_dir=INIT_DIR, clears holdoff and drop_count.
  - RUN -> IDLE on game_over: same edge flushes FIFO; cur_dir holds its value.
  - start in RUN restarts the game: same flush/reload, stays in RUN.
  - start and game_over in the same cycle: game_over wins.
- Reference direction for turn checks: FIFO tail entry if FIFO is non-empty (pre-pop value), else cur_dir.
- Accept rule (RUN only), on cmd_valid, all must hold:
  - holdoff counter == 0;
  - cmd_dir != reference;
  - cmd_dir is not opposite to reference (opposite = bit1 equal and bit0 differs);
  - FIFO not full after any same-cycle pop.
- Accept action: write cmd_dir at tail, load holdoff counter with HOLDOFF_CYCLES.
- Holdoff counter decrements by 1 per cycle while nonzero.
- Any rejected cmd_valid in RUN increments drop_count (saturating). Holdoff is not reloaded on reject.
- Tick in RUN with FIFO non-empty:
  - at that edge, pop head into cur_dir and set dir_update=1 for exactly one cycle;
  - latency: new cur_dir visible the cycle after tick is sampled.
- Tick with FIFO empty: no change, dir_update=0.
- Simultaneous tick and cmd_valid:
  - pop and push occur on the same edge; queue_count is net unchanged when both succeed;
  - a full FIFO accepts the push because the pop frees a slot.
- queue_count tracks occupancy exactly, in 0..DEPTH. Read/write pointers wrap modulo DEPTH.
- start/game_over edge: the flush takes priority over any same-cycle push or pop.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. Reset, start, HOLDOFF_CYCLES=4, cur_dir=3: cmd_dir=0 accepted, queue_count=1. Tick -> next cycle cur_dir=0, dir_update high 1 cycle, queue_count=0.
2. cur_dir=3: cmd_dir=2 (reversal) and then cmd_dir=3 (no-op), spaced beyond holdoff -> both rejected, drop_count=2, queue_count=0.
3. Holdoff: cmd_dir=0 accepted, then cmd_dir=2 two cycles later -> dropped; the same command 5 cycles after accept -> accepted, queue_count=2, FIFO order 0,2.
4. HOLDOFF_CYCLES=0, fill 4 alternating legal turns (0,2,1,3) -> queue_count=4. 5th cmd_dir=0 -> dropped. 5th repeated with simultaneous tick -> accepted, queue_count stays 4, cur_dir=0.
5. FIFO holding 2 entries, game_over pulse -> running=0, queue_count=0. cmd_valid and tick in IDLE -> no change, drop_count unchanged. start -> cur_dir=3, drop_count=0.
6. Assert reset_n low asynchronously mid-tick with queue_count=3 -> outputs go to reset values immediately without waiting for a clock edge. drop_count driven to 255 by 300 rejects stays at 255.
